// File: rtl/fk_cmd_sequencer.sv
// Command sequencer for a forward-kinematics engine.
// Joint-angle commands are queued in a small FIFO, issued one at a time to the
// FK engine with a start pulse, and the engine's result is held for a consumer
// together with the sequence tag of the command that produced it. A watchdog
// abandons a command whose engine never answers and raises a sticky error.
module fk_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_theta1,
    input  logic [15:0] cmd_theta2,
    input  logic [15:0] cmd_theta3,
    output logic        fk_start,
    output logic [15:0] fk_theta1,
    output logic [15:0] fk_theta2,
    output logic [15:0] fk_theta3,
    input  logic        fk_done,
    input  logic [31:0] fk_X,
    input  logic [31:0] fk_Y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_X,
    output logic [31:0] res_Y,
    output logic [7:0]  res_tag,
    output logic        err,
    input  logic        err_clr,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t state_reg;
    state_t state_next;

    // FIFO storage and bookkeeping; pointers wrap naturally since DEPTH is a power of two
    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [47:0]   head_word;
    logic [15:0]   head_theta [3];

    logic [TW-1:0] timer_reg;
    logic [7:0]    tag_ctr_reg;
    logic [7:0]    issue_tag_reg;

    logic do_push;
    logic do_pop;
    logic do_capture;
    logic do_timeout;
    logic do_release;

    assign cmd_ready = (count_reg != FULL_COUNT);
    assign do_push   = cmd_valid && cmd_ready;
    assign busy      = (state_reg != ST_IDLE) || (count_reg != '0);
    assign head_word = mem[rd_ptr_reg];

    // Split the packed head entry into its three joint angles
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_head
            assign head_theta[gi] = head_word[16*gi +: 16];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-cycle action decode; fk_done beats the timeout in the same cycle
    always_comb begin
        state_next = state_reg;
        do_pop     = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        do_release = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    do_pop     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fk_done) begin
                    do_capture = 1'b1;
                    state_next = ST_HOLD;
                end else if (timer_reg == TIMER_LAST) begin
                    do_timeout = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    do_release = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FIFO storage write; no reset so the array can map onto block RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= {cmd_theta3, cmd_theta2, cmd_theta1};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Issue path: registered angles, one-cycle start pulse and sequence tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fk_start      <= 1'b0;
            fk_theta1     <= '0;
            fk_theta2     <= '0;
            fk_theta3     <= '0;
            tag_ctr_reg   <= '0;
            issue_tag_reg <= '0;
        end else begin
            fk_start <= do_pop;
            if (do_pop) begin
                fk_theta1     <= head_theta[0];
                fk_theta2     <= head_theta[1];
                fk_theta3     <= head_theta[2];
                issue_tag_reg <= tag_ctr_reg;
                tag_ctr_reg   <= tag_ctr_reg + 8'd1;
            end
        end
    end

    // Watchdog timer: zero in the fk_start cycle, counts while waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_reg <= '0;
        end else if (do_pop || do_timeout || do_capture) begin
            timer_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    // Result capture and hold until the consumer takes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_X     <= '0;
            res_Y     <= '0;
            res_tag   <= '0;
        end else if (do_capture) begin
            res_valid <= 1'b1;
            res_X     <= fk_X;
            res_Y     <= fk_Y;
            res_tag   <= issue_tag_reg;
        end else if (do_release) begin
            res_valid <= 1'b0;
        end
    end

    // Sticky error flag; a timeout outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (do_timeout) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: doc/fk_cmd_sequencer.md
FK_CMD_SEQUENCER -- requirements
Module: fk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth (power of 2, at least 2).
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles to wait for fk_done after fk_start.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 cmd_valid  in  1  joint-angle command offered.
REQ-006 cmd_ready  out  1  FIFO can accept (= not full).
REQ-007 cmd_theta1/cmd_theta2/cmd_theta3  in  16 each  signed Q-format joint angles.
REQ-008 fk_start  out  1  one-cycle start pulse to the FK engine.
REQ-009 fk_theta1/fk_theta2/fk_theta3  out  16 each  registered angles driven to the FK engine.
REQ-010 fk_done  in  1  FK engine completion pulse; fk_X/fk_Y valid in the same cycle.
REQ-011 fk_X/fk_Y  in  32 each  signed FK results.
REQ-012 res_valid  out  1  result held for consumer.
REQ-013 res_ready  in  1  consumer accepts result.
REQ-014 res_X/res_Y  out  32 each  captured results.
REQ-015 res_tag  out  8  sequence number of the command that produced the result.
REQ-016 err  out  1  sticky timeout flag.
REQ-017 err_clr  in  1  clears err.
REQ-018 busy  out  1  high when state is not IDLE or the FIFO is non-empty.

Function
REQ-019 FIFO push on cmd_valid&&cmd_ready; cmd_ready=0 when count==DEPTH; no push bypass (an entry becomes visible one edge after the push).
REQ-020 Pointers wrap modulo DEPTH; simultaneous push and pop leave count unchanged; pop never occurs when empty.
REQ-021 FSM states: IDLE, WAIT, HOLD.
REQ-022 IDLE with count>0: at the edge, pop head into fk_theta1..3, set fk_start=1, tag_ctr->issue tag, goto WAIT.
REQ-023 fk_start shall be high for exactly one cycle per issued command.
REQ-024 fk_theta1..3 shall stay stable from fk_start until the state leaves WAIT.
REQ-025 WAIT: timer counts cycles from 0; on fk_done, res_X<=fk_X, res_Y<=fk_Y, res_tag<=issue tag, res_valid<=1, goto HOLD.
REQ-026 WAIT timeout: when the timer reaches TIMEOUT-1 without fk_done, set err=1, discard the command (no result), goto IDLE.
REQ-027 If fk_done coincides with the timeout cycle, fk_done wins and err is not set.
REQ-028 HOLD: on res_valid&&res_ready, clear res_valid and goto IDLE; the next pop happens no earlier than the following edge.
REQ-029 res_X/res_Y/res_tag shall remain stable while res_valid=1.
REQ-030 fk_done outside WAIT shall be ignored.
REQ-031 Issue tag: 8-bit counter, increments per issued command (including timed-out ones), wraps 255->0.
REQ-032 err is sticky; err_clr clears it; if err_clr and a timeout occur in the same cycle, err=1.
REQ-033 Minimum latency: push at edge E0 -> fk_start high in the cycle after E1.

Reset
REQ-034 rst=0 asynchronously forces: state IDLE, FIFO empty, cmd_ready=1, fk_start=0, fk_theta*=0, res_valid=0, res_X=res_Y=0, res_tag=0, tag counter=0, timer=0, err=0, busy=0.
REQ-035 Reset mid-operation (any state) discards all queued and in-flight commands; fk_done arriving after deassertion is ignored.

Verification
REQ-036 Single command (0x2000,0x1000,0) into empty FIFO; FK model returns done after 40 cycles with X=100, Y=-50 -> exactly one fk_start, res_valid with res_X=100, res_Y=-50, res_tag=0.
REQ-037 Push 5 commands back-to-back with DEPTH=4 and an FK stalled -> cmd_ready drops after the 4th FIFO entry; all accepted commands are issued in order with tags 0..4.
REQ-038 FK model never asserts done, TIMEOUT=16 -> err=1 exactly 16 cycles after fk_start; the FSM returns to IDLE and the next command issues with the next tag.
REQ-039 fk_done on the timeout cycle -> result captured, err=0; err_clr and a timeout in the same cycle -> err=1.
REQ-040 res_ready held 0 for 20 cycles -> res fields stable, no new fk_start; when res_ready=1, IDLE resumes and the next command issues.
REQ-041 rst=0 during WAIT with 2 entries queued -> all outputs at reset values immediately; after release, no fk_start until a new push.
